// File: rtl/seven_scan_mux.sv
// Time-multiplexed seven-segment driver: scans DIGITS digits with a prescaled
// refresh, PWM brightness per slot, leading-zero blanking, blink and hex decode.
module seven_scan_mux #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 1,
  parameter int BRIGHT_W     = 3,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [4*DIGITS-1:0]        big_bin,
  input  logic [DIGITS-1:0]          dp_in,
  input  logic                       blank_lz,
  input  logic [DIGITS-1:0]          blink_mask,
  input  logic [BRIGHT_W-1:0]        brightness,
  output logic [DIGITS-1:0]          AN,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic [3:0]                 small_bin,
  output logic [$clog2(DIGITS)-1:0]  digit_idx
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0]    PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [BRIGHT_W-1:0] SUB_MAX = '1;
  localparam logic [IDX_W-1:0]    IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [FR_W-1:0]     FR_MAX  = FR_W'(BLINK_FRAMES - 1);

  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [BRIGHT_W-1:0] sub_cnt_q, sub_cnt_d;
  logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
  logic [FR_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic                blink_phase_q, blink_phase_d;

  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [3:0]          small_bin_q, small_bin_d;
  logic [IDX_W-1:0]    digit_idx_q, digit_idx_d;

  logic                tick;
  logic                slot_end;
  logic                frame_end;
  logic [3:0]          cur_nib;
  logic                cur_dp_req;
  logic                cur_blink;
  logic                upper_zero;
  logic                lz_blank;
  logic                lit;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'ha: s = 7'b0001000;
      4'hb: s = 7'b0000011;
      4'hc: s = 7'b1000110;
      4'hd: s = 7'b0100001;
      4'he: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Scan timing chain: prescaler -> PWM sub-slot -> digit -> blink frame.
  always_comb begin
    tick          = (pre_cnt_q == PRE_MAX);
    slot_end      = tick && (sub_cnt_q == SUB_MAX);
    frame_end     = slot_end && (scan_idx_q == IDX_MAX);

    pre_cnt_d     = tick ? '0 : pre_cnt_q + 1'b1;
    sub_cnt_d     = tick ? sub_cnt_q + 1'b1 : sub_cnt_q;
    scan_idx_d    = scan_idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;

    if (slot_end) begin
      scan_idx_d = (scan_idx_q == IDX_MAX) ? '0 : scan_idx_q + 1'b1;
    end
    if (frame_end) begin
      if (frame_cnt_q == FR_MAX) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Per-digit selection; a digit is a leading zero when it and every digit
  // above it are zero.
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp_req = 1'b0;
    cur_blink  = 1'b0;
    upper_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (scan_idx_q == IDX_W'(i)) begin
        cur_nib    = big_bin[4*i +: 4];
        cur_dp_req = dp_in[i];
        cur_blink  = blink_mask[i];
      end
      if ((i >= int'(scan_idx_q)) && (big_bin[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    lz_blank = blank_lz && (scan_idx_q != '0) && upper_zero;
    lit      = (sub_cnt_q <= brightness) && !(cur_blink && blink_phase_q) && !lz_blank;
  end

  always_comb begin
    digit_idx_d = scan_idx_q;
    small_bin_d = cur_nib;
    an_d        = '1;
    seg_d       = 7'b1111111;
    dp_d        = 1'b1;
    if (lit) begin
      an_d  = ~(DIGITS'(1) << scan_idx_q);
      seg_d = hex_to_seg(cur_nib);
      dp_d  = ~cur_dp_req;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q     <= '0;
      sub_cnt_q     <= '0;
      scan_idx_q    <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= '1;
      seg_q         <= 7'b1111111;
      dp_q          <= 1'b1;
      small_bin_q   <= 4'h0;
      digit_idx_q   <= '0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      sub_cnt_q     <= sub_cnt_d;
      scan_idx_q    <= scan_idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      small_bin_q   <= small_bin_d;
      digit_idx_q   <= digit_idx_d;
    end
  end

  assign AN        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign small_bin = small_bin_q;
  assign digit_idx = digit_idx_q;

endmodule
